// File: rtl/timer_irq_ctrl_if.sv
// Register bus between the MMU and the timer/interrupt block.
// The MMU side drives address, write strobe and data; the block returns read data.
interface timer_irq_ctrl_if;
  logic [15:0] addr;
  logic        we;
  logic [7:0]  wdata;
  logic [7:0]  rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_irq_ctrl.sv
// DIV/TIMA/TMA/TAC timer with delayed TMA reload, plus the IF/IE interrupt registers
// that feed the CPU core.
module timer_irq_ctrl #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned OVF_DELAY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  timer_irq_ctrl_if.slave       bus,
  input  logic [4:0]            irq_pulse,
  output logic [7:0]            mmio_reg_IF,
  output logic [7:0]            mmio_reg_IE,
  output logic                  timer_irq
);

  localparam int unsigned DlyW = (OVF_DELAY > 2) ? $clog2(OVF_DELAY) : 1;

  typedef enum logic [0:0] {StIdle, StDelay} ovf_state_e;

  ovf_state_e           state_q;
  logic [DlyW-1:0]      dly_q;
  logic [DIV_WIDTH-1:0] counter_q;
  logic [7:0]           tima_q;
  logic [7:0]           tma_q;
  logic [2:0]           tac_q;
  logic [4:0]           if_q;
  logic [7:0]           ie_q;
  logic                 tick_q;

  logic wr_div, wr_tima, wr_tma, wr_tac, wr_if, wr_ie;
  logic sel_bit, tick_sig, tick_fall, reload;
  logic [4:0] if_d;

  always_comb begin
    wr_div  = bus.we && (bus.addr == 16'hFF04);
    wr_tima = bus.we && (bus.addr == 16'hFF05);
    wr_tma  = bus.we && (bus.addr == 16'hFF06);
    wr_tac  = bus.we && (bus.addr == 16'hFF07);
    wr_if   = bus.we && (bus.addr == 16'hFF0F);
    wr_ie   = bus.we && (bus.addr == 16'hFFFF);
  end

  always_comb begin
    unique case (tac_q[1:0])
      2'b00:   sel_bit = counter_q[9];
      2'b01:   sel_bit = counter_q[3];
      2'b10:   sel_bit = counter_q[5];
      default: sel_bit = counter_q[7];
    endcase
    tick_sig  = tac_q[2] & sel_bit;
    // Any 1->0 drop ticks, including those caused by DIV or TAC writes.
    tick_fall = tick_q & ~tick_sig;
    reload    = (state_q == StDelay) && (dly_q == '0) && !wr_tima;
    // Hardware set bits are OR'd in last so they win over a CPU clear.
    if_d      = (wr_if ? bus.wdata[4:0] : if_q) | (irq_pulse & 5'b11011) | {2'b00, reload, 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      dly_q     <= '0;
      counter_q <= '0;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'b000;
      if_q      <= 5'b00000;
      ie_q      <= 8'h00;
      tick_q    <= 1'b0;
      timer_irq <= 1'b0;
    end else begin
      counter_q <= wr_div ? '0 : counter_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      tick_q    <= tick_sig;
      timer_irq <= reload;
      if_q      <= if_d;
      if (wr_tma) tma_q <= bus.wdata;
      if (wr_tac) tac_q <= bus.wdata[2:0];
      if (wr_ie)  ie_q  <= bus.wdata;

      if (wr_tima) begin
        tima_q  <= bus.wdata;
        state_q <= StIdle;
      end else if (reload) begin
        tima_q  <= wr_tma ? bus.wdata : tma_q;
        state_q <= StIdle;
      end else begin
        if (state_q == StDelay) dly_q <= dly_q - DlyW'(1);
        if (tick_fall) begin
          if (tima_q == 8'hFF) begin
            tima_q  <= 8'h00;
            state_q <= StDelay;
            dly_q   <= DlyW'(OVF_DELAY - 1);
          end else begin
            tima_q <= tima_q + 8'd1;
          end
        end
      end
    end
  end

  always_comb begin
    case (bus.addr)
      16'hFF04: bus.rdata = counter_q[15:8];
      16'hFF05: bus.rdata = tima_q;
      16'hFF06: bus.rdata = tma_q;
      16'hFF07: bus.rdata = {5'b11111, tac_q};
      16'hFF0F: bus.rdata = {3'b111, if_q};
      16'hFFFF: bus.rdata = ie_q;
      default:  bus.rdata = 8'hFF;
    endcase
  end

  assign mmio_reg_IF = {3'b111, if_q};
  assign mmio_reg_IE = ie_q;

endmodule
